sram16_responder: RTL and testbench
===================================

# sram16_responder

Synthesizable responder for the 16-bit asynchronous-SRAM bus driven by the core's DRAM controller: `data`, `write_en` and 19-bit `addr`. It stores halfwords in on-chip RAM, answers reads combinationally as an external SRAM chip would, and accepts bus writes on the clock edge. A byte-stream loader port (boot/UART side) preloads memory through a handshake-driven FSM. That port arbitrates against bus writes.

## Interface

**Parameters**
- `DEPTH`, default 65536: number of 16-bit words. Must be a power of two. The RAM index is `addr mod DEPTH`.

**Ports**
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `data`, inout, 16: SRAM data bus.
- `write_en`, in, 1: high means the controller drives `data` and writes `mem[addr]`.
- `addr`, in, 19: halfword address. Lower address holds the more-significant halfword of a 64-bit datum.
- `ld_start`, in, 1: pulse; starts a load at `ld_base`. Honoured only in `L_IDLE`.
- `ld_base`, in, 19: load start address.
- `ld_valid`, in, 1: loader byte valid.
- `ld_byte`, in, 8: loader byte. The first byte of a pair goes to `[15:8]`.
- `ld_ready`, out, 1: loader can accept a byte.
- `ld_stop`, in, 1: pulse; ends the load.
- `ld_done`, out, 1: one-cycle pulse when the load ends.
- `ld_words`, out, 20: words committed since the last `ld_start`.
- `wr_cnt`, out, 32: present only with `SRAM_STATS_EN`.
- `stall_cnt`, out, 32: present only with `SRAM_STATS_EN`.

## Operation

**Bus side**
- `data` is driven with `mem[addr mod DEPTH]` when `rst`=1 and `write_en`=0. Otherwise `data` is 16'bz.
- The read is combinational: same-cycle data, zero latency.
- At a rising edge with `rst`=1 and `write_en`=1: `mem[addr mod DEPTH] <= data`.
- RAM contents are not cleared by reset.

**Loader FSM**
- `L_IDLE`
  - Pulsing `ld_start` sets `ptr <= ld_base`, `ld_words <= 0`, clears `stop_pend`, and moves to `L_HI`.
  - `ld_stop` is ignored.
- `L_HI`
  - Accepting a byte (`ld_valid && ld_ready`) sets `hi <= ld_byte` and moves to `L_LO`.
  - Otherwise, if `stop_pend` is set, moves to `L_IDLE`.
- `L_LO`
  - Accepting a byte sets `lo <= ld_byte` and moves to `L_COMMIT`.
  - Otherwise, if `stop_pend` is set, sets `lo <= 8'h00` (pad) and moves to `L_COMMIT`.
- `L_COMMIT`
  - If `write_en`=0: `mem[ptr mod DEPTH] <= {hi,lo}`, then `ptr <= ptr+1` (wraps mod 2^19) and `ld_words <= ld_words+1` (wraps mod 2^20).
  - After the write, moves to `L_IDLE` if `stop_pend` is set, else to `L_HI`.
  - If `write_en`=1: holds (stall). The bus always wins; the two write paths never collide.
- `ld_stop` in any non-idle state sets `stop_pend`. `stop_pend` clears on entering `L_IDLE`.
- If `ld_stop` and an accepted byte occur in the same cycle, the byte is taken and the stop is latched.
- `ld_ready` = 1 in `L_HI` or `L_LO` when `stop_pend` is 0. It is a registered-state decode with no input dependency.
- `ld_done` = 1 for exactly the cycle after the transition into `L_IDLE` caused by a stop.
- `ld_start` outside `L_IDLE` is ignored.

## Timing

- Reset values: FSM `L_IDLE`, `ld_ready` 0, `ld_done` 0, `ld_words` 0, `ptr` 0, `stop_pend` 0, `wr_cnt` and `stall_cnt` 0. `data` is 'z while `rst`=0. Bus writes are ignored while `rst`=0.
- Reset asserted mid-load: the FSM returns to `L_IDLE`, a partial word is discarded, RAM already written keeps its contents, and no `ld_done` is generated.
- Loader throughput is 3 cycles per word minimum, plus one cycle per `write_en`=1 cycle while in `L_COMMIT`.
- Read-after-write to the same address (bus or loader): the same cycle returns the old value; the next cycle returns the new value.
- Controller 4-beat write burst (`write_en` high for 4 consecutive cycles): one word stored per cycle.

## Configuration

- `SRAM_STATS_EN` defined:
  - `wr_cnt` counts cycles with `write_en`=1.
  - `stall_cnt` counts `L_COMMIT` cycles held by `write_en`.
  - Both are 32-bit, saturate at 32'hFFFFFFFF, and are cleared by reset.
- `SRAM_STATS_EN` undefined: both ports and their counters are absent. All other behaviour is identical.

## Test plan

- **Bus write and readback.** Write 4 beats at addr 0x40000..0x40003 with 16'h1122, 16'h3344, 16'h5566, 16'h7788. Read with `write_en`=0 → `data` equals each value in the same cycle; `data` is 'z in cycles where `write_en`=1.
- **Loader load.** Reset, then `ld_start` with `ld_base`=0x00010 and bytes AA,BB,CC,DD, then `ld_stop` → mem[0x10]=16'hAABB, mem[0x11]=16'hCCDD, `ld_words`=2, `ld_done` high for one cycle.
- **Bus-priority stall.** Hold `write_en`=1 for 3 cycles while the loader sits in `L_COMMIT` → the commit is delayed 3 cycles and both writes land intact. With stats: `stall_cnt`=3 and `wr_cnt`=3.
- **Stop mid-word and same-cycle stop.**
  - `ld_stop` after a single byte 0x5A → the word stored is 16'h5A00 and the FSM returns to `L_IDLE`.
  - Stop coinciding with an accepted byte → the byte is kept.
- **Reset mid-load.** Drop `rst` in `L_LO` → `ld_ready`=0, `ld_words`=0, no commit, earlier words still readable.
- **Wrap.** `ld_base`=19'h7FFFF with 2 words → the second word lands at address 0. With `DEPTH`=65536, `addr` 0x10000 aliases to 0x00000.

Source files
------------

// File: rtl/sram16_responder.sv
// sram16_responder: on-chip stand-in for a 16-bit asynchronous SRAM chip.
// Reads are combinational from the addressed word, bus writes land on the clock
// edge, and a byte-stream loader FSM packs byte pairs into halfwords and commits
// them whenever the bus is not writing (the bus always has priority).
// Optional feature macro: SRAM_STATS_EN adds the wr_cnt / stall_cnt counters.
module sram16_responder #(
    parameter int unsigned DEPTH = 65536
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [15:0] data,
    input  logic        write_en,
    input  logic [18:0] addr,
    input  logic        ld_start,
    input  logic [18:0] ld_base,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    output logic        ld_ready,
    input  logic        ld_stop,
    output logic        ld_done,
    output logic [19:0] ld_words
`ifdef SRAM_STATS_EN
    ,
    output logic [31:0] wr_cnt,
    output logic [31:0] stall_cnt
`endif
);

    // DEPTH is a power of two, so "mod DEPTH" is just the low address bits.
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        LIdle,
        LHi,
        LLo,
        LCommit
    } ld_state_e;

    ld_state_e     state_q;
    logic [18:0]   ptr_q;
    logic [7:0]    hi_q;
    logic [7:0]    lo_q;
    logic          stop_pend_q;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] bus_idx;
    logic [AW-1:0] ptr_idx;
    logic          accept;
    logic          commit_go;

    assign bus_idx   = addr[AW-1:0];
    assign ptr_idx   = ptr_q[AW-1:0];
    assign accept    = ld_valid && ld_ready;
    assign commit_go = (state_q == LCommit) && !write_en;

    // Address bits above the RAM index only alias; keep them visibly consumed.
    if (AW < 19) begin : g_alias
        logic unused_hi_bits;
        assign unused_hi_bits = ^{addr[18:AW], ptr_q[18:AW]};
    end

    // Ready depends only on registered state so the loader never sees a combinational path.
    assign ld_ready = ((state_q == LHi) || (state_q == LLo)) && !stop_pend_q;

    // Drive the bus like an SRAM chip: only when out of reset and not being written.
    assign data = (rst && !write_en) ? mem[bus_idx] : 16'hzzzz;

    // Single write port: a bus write pre-empts a loader commit in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (write_en) begin
                mem[bus_idx] <= data;
            end else if (commit_go) begin
                mem[ptr_idx] <= {hi_q, lo_q};
            end
        end
    end

    // Loader FSM: collect high byte, low byte (or pad on stop), then commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= LIdle;
            ptr_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            stop_pend_q <= 1'b0;
            ld_words    <= '0;
            ld_done     <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            // A stop is only latched here; the state cases decide when it takes effect.
            if (ld_stop && (state_q != LIdle)) begin
                stop_pend_q <= 1'b1;
            end
            unique case (state_q)
                LIdle: begin
                    if (ld_start) begin
                        ptr_q       <= ld_base;
                        ld_words    <= '0;
                        stop_pend_q <= 1'b0;
                        state_q     <= LHi;
                    end
                end
                LHi: begin
                    if (accept) begin
                        hi_q    <= ld_byte;
                        state_q <= LLo;
                    end else if (stop_pend_q) begin
                        stop_pend_q <= 1'b0;
                        ld_done     <= 1'b1;
                        state_q     <= LIdle;
                    end
                end
                LLo: begin
                    if (accept) begin
                        lo_q    <= ld_byte;
                        state_q <= LCommit;
                    end else if (stop_pend_q) begin
                        lo_q    <= 8'h00;
                        state_q <= LCommit;
                    end
                end
                LCommit: begin
                    // Held while the bus writes; the RAM write itself is in the block above.
                    if (!write_en) begin
                        ptr_q    <= ptr_q + 19'd1;
                        ld_words <= ld_words + 20'd1;
                        if (stop_pend_q) begin
                            stop_pend_q <= 1'b0;
                            ld_done     <= 1'b1;
                            state_q     <= LIdle;
                        end else begin
                            state_q <= LHi;
                        end
                    end
                end
                default: state_q <= LIdle;
            endcase
        end
    end

`ifdef SRAM_STATS_EN
    // Saturating activity counters: bus write cycles and loader commit stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (write_en && (wr_cnt != 32'hFFFF_FFFF)) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            if (write_en && (state_q == LCommit) && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram16_responder.sv
// Self-checking bench for sram16_responder: a vector table for bus accesses,
// hand-timed loader sequences for the multi-cycle corners, and randomized
// loads racing random bus traffic against a word-level memory model.
// Build with SRAM_STATS_EN defined to also check the statistics counters.
module tb_sram16_responder;

    localparam int unsigned DEPTH = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        write_en = 1'b0;
    logic        drv = 1'b0;
    logic [15:0] wdata = '0;
    logic [18:0] addr = '0;
    logic        ld_start = 1'b0;
    logic [18:0] ld_base = '0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        ld_stop = 1'b0;
    logic        ld_ready;
    logic        ld_done;
    logic [19:0] ld_words;
    wire  [15:0] data;
`ifdef SRAM_STATS_EN
    logic [31:0] wr_cnt;
    logic [31:0] stall_cnt;
`endif

    assign data = drv ? wdata : 16'hzzzz;

    sram16_responder #(
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .write_en (write_en),
        .addr     (addr),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_valid (ld_valid),
        .ld_byte  (ld_byte),
        .ld_ready (ld_ready),
        .ld_stop  (ld_stop),
        .ld_done  (ld_done),
        .ld_words (ld_words)
`ifdef SRAM_STATS_EN
        ,
        .wr_cnt   (wr_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [15:0] mdl [int];

    typedef struct {
        logic        we;
        logic [18:0] a;
        logic [15:0] d;   // write data, or expected read data
    } bus_vec_t;

    bus_vec_t vec [11];

    function automatic int idx(input logic [18:0] a);
        return int'(a) % int'(DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [18:0] a, input logic [15:0] v);
        write_en = 1'b1;
        drv = 1'b1;
        addr = a;
        wdata = v;
        mdl[idx(a)] = v;
        @(negedge clk);
        write_en = 1'b0;
        drv = 1'b0;
    endtask

    task automatic bus_read(input logic [18:0] a, input string name);
        write_en = 1'b0;
        drv = 1'b0;
        addr = a;
        #1;
        chk(name, {16'h0, data}, {16'h0, mdl[idx(a)]});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        write_en = 1'b0;
        drv = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_stop = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_load(input logic [18:0] b);
        ld_start = 1'b1;
        ld_base = b;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    // Offer a byte until ld_ready; optionally raise ld_stop in the accepting cycle.
    task automatic send_byte(input logic [7:0] b, input logic with_stop);
        int n;
        n = 0;
        ld_valid = 1'b1;
        ld_byte = b;
        while (!ld_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("byte_handshake", {31'h0, ld_ready}, 32'h1);
        ld_stop = with_stop;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_stop = 1'b0;
    endtask

    task automatic stop_pulse();
        ld_stop = 1'b1;
        @(negedge clk);
        ld_stop = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!ld_done && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, {31'h0, ld_done}, 32'h1);
        @(negedge clk);
        chk({name, "_done_pulse"}, {31'h0, ld_done}, 32'h0);
    endtask

    // One random round: a load of random length races random bus traffic.
    task automatic rand_round(input int r);
        logic [18:0] base;
        logic [7:0]  bs [10];
        int          n;
        int          nw;
        base = 19'h08000 + 19'(r * 64);
        n = int'($urandom_range(1, 9));
        for (int j = 0; j < n; j++) bs[j] = 8'($urandom);
        fork
            begin
                start_load(base);
                for (int j = 0; j < n; j++) send_byte(bs[j], 1'b0);
                stop_pulse();
                wait_done("rand");
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    logic [18:0] a;
                    a = 19'h0C000 + 19'($urandom_range(0, 15));
                    if ($urandom_range(0, 1) == 1) begin
                        write_en = 1'b1;
                        drv = 1'b1;
                        addr = a;
                        wdata = 16'($urandom);
                        mdl[idx(a)] = wdata;
                    end else begin
                        write_en = 1'b0;
                        drv = 1'b0;
                        addr = a;
                        #1;
                        chk("rand_bus_read", {16'h0, data}, {16'h0, mdl[idx(a)]});
                    end
                    @(negedge clk);
                end
                write_en = 1'b0;
                drv = 1'b0;
            end
        join
        nw = (n + 1) / 2;
        for (int w = 0; w < nw; w++) begin
            logic [7:0] lo;
            lo = (2 * w + 1 < n) ? bs[2 * w + 1] : 8'h00;
            mdl[idx(base + 19'(w))] = {bs[2 * w], lo};
        end
        chk("rand_words", {12'h0, ld_words}, 32'(nw));
        for (int w = 0; w < nw; w++) bus_read(base + 19'(w), "rand_load_read");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'h0, ld_ready}, 32'h0);
        chk("rst_done", {31'h0, ld_done}, 32'h0);
        chk("rst_words", {12'h0, ld_words}, 32'h0);
`ifdef SRAM_STATS_EN
        chk("rst_wr_cnt", wr_cnt, 32'h0);
        chk("rst_stall_cnt", stall_cnt, 32'h0);
`endif

        // Table: 4-beat write burst, same-cycle readback, address aliasing
        vec[0]  = '{1'b1, 19'h40000, 16'h1122};
        vec[1]  = '{1'b1, 19'h40001, 16'h3344};
        vec[2]  = '{1'b1, 19'h40002, 16'h5566};
        vec[3]  = '{1'b1, 19'h40003, 16'h7788};
        vec[4]  = '{1'b0, 19'h40000, 16'h1122};
        vec[5]  = '{1'b0, 19'h40001, 16'h3344};
        vec[6]  = '{1'b0, 19'h40002, 16'h5566};
        vec[7]  = '{1'b0, 19'h40003, 16'h7788};
        vec[8]  = '{1'b0, 19'h00000, 16'h1122};
        vec[9]  = '{1'b0, 19'h50003, 16'h7788};
        vec[10] = '{1'b0, 19'h10002, 16'h5566};
        for (int i = 0; i < 11; i++) begin
            addr = vec[i].a;
            if (vec[i].we) begin
                write_en = 1'b1;
                drv = 1'b1;
                wdata = vec[i].d;
                mdl[idx(vec[i].a)] = vec[i].d;
            end else begin
                write_en = 1'b0;
                drv = 1'b0;
                #1;
                chk($sformatf("vec%0d", i), {16'h0, data}, {16'h0, vec[i].d});
            end
            @(negedge clk);
        end
        write_en = 1'b0;
        drv = 1'b0;

        // Loader: AA BB CC DD at 0x10, cycle-exact, with read-after-commit on 0x10
        bus_write(19'h10, 16'hDEAD);
        addr = 19'h10;
        ld_start = 1'b1;
        ld_base = 19'h10;
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_byte = 8'hAA;
        #1;
        chk("ld_ready_hi", {31'h0, ld_ready}, 32'h1);
        chk("raw_before", {16'h0, data}, 32'hDEAD);
        @(negedge clk);
        ld_byte = 8'hBB;
        #1;
        chk("ld_ready_lo", {31'h0, ld_ready}, 32'h1);
        @(negedge clk);
        ld_byte = 8'hCC;
        #1;
        chk("ready_commit", {31'h0, ld_ready}, 32'h0);
        chk("words_commit", {12'h0, ld_words}, 32'h0);
        chk("raw_same_cycle", {16'h0, data}, 32'hDEAD);
        @(negedge clk);
        ld_start = 1'b1;
        ld_base = 19'h500;
        #1;
        chk("words_one", {12'h0, ld_words}, 32'h1);
        chk("raw_next_cycle", {16'h0, data}, 32'hAABB);
        chk("ready_after", {31'h0, ld_ready}, 32'h1);
        @(negedge clk);
        ld_start = 1'b0;
        ld_byte = 8'hDD;
        #1;
        chk("ready_lo2", {31'h0, ld_ready}, 32'h1);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        chk("ready_commit2", {31'h0, ld_ready}, 32'h0);
        @(negedge clk);
        #1;
        chk("words_two", {12'h0, ld_words}, 32'h2);
        ld_stop = 1'b1;
        @(negedge clk);
        ld_stop = 1'b0;
        #1;
        chk("ready_stop_pend", {31'h0, ld_ready}, 32'h0);
        chk("done_early", {31'h0, ld_done}, 32'h0);
        @(negedge clk);
        chk("done_high", {31'h0, ld_done}, 32'h1);
        chk("words_final", {12'h0, ld_words}, 32'h2);
        @(negedge clk);
        chk("done_one_cycle", {31'h0, ld_done}, 32'h0);
        mdl[idx(19'h10)] = 16'hAABB;
        mdl[idx(19'h11)] = 16'hCCDD;
        bus_read(19'h10, "load_w0");
        bus_read(19'h11, "load_w1");

        // Bus-priority stall: 3 bus writes while the loader sits in commit
        do_reset();
        start_load(19'h20);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        for (int i = 0; i < 3; i++) begin
            write_en = 1'b1;
            drv = 1'b1;
            addr = 19'h30 + 19'(i);
            wdata = 16'hA000 + 16'(i);
            mdl[idx(addr)] = wdata;
            #1;
            chk("stall_words", {12'h0, ld_words}, 32'h0);
            @(negedge clk);
        end
        write_en = 1'b0;
        drv = 1'b0;
        #1;
        chk("stall_words_end", {12'h0, ld_words}, 32'h0);
        @(negedge clk);
        chk("stall_committed", {12'h0, ld_words}, 32'h1);
        stop_pulse();
        wait_done("stall");
`ifdef SRAM_STATS_EN
        chk("stall_cnt", stall_cnt, 32'h3);
        chk("wr_cnt", wr_cnt, 32'h3);
`endif
        mdl[idx(19'h20)] = 16'h1234;
        bus_read(19'h20, "stall_loader_word");
        for (int i = 0; i < 3; i++) bus_read(19'h30 + 19'(i), "stall_bus_word");

        // Stop mid-word pads the low byte
        start_load(19'h50);
        send_byte(8'h5A, 1'b0);
        stop_pulse();
        wait_done("midword");
        chk("midword_words", {12'h0, ld_words}, 32'h1);
        chk("midword_ready", {31'h0, ld_ready}, 32'h0);
        mdl[idx(19'h50)] = 16'h5A00;
        bus_read(19'h50, "midword_pad");

        // Stop coinciding with an accepted low byte, then with a high byte
        start_load(19'h60);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        wait_done("samecyc_lo");
        chk("samecyc_lo_words", {12'h0, ld_words}, 32'h1);
        start_load(19'h61);
        send_byte(8'h33, 1'b1);
        wait_done("samecyc_hi");
        chk("samecyc_hi_words", {12'h0, ld_words}, 32'h1);
        mdl[idx(19'h60)] = 16'h1122;
        mdl[idx(19'h61)] = 16'h3300;
        bus_read(19'h60, "samecyc_lo_kept");
        bus_read(19'h61, "samecyc_hi_kept");

        // Reset in L_LO: no commit, no done, bus write during reset ignored
        bus_write(19'h71, 16'hBEEF);
        bus_write(19'h72, 16'h2222);
        start_load(19'h70);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        rst = 1'b0;
        write_en = 1'b1;
        drv = 1'b1;
        addr = 19'h72;
        wdata = 16'h1111;
        @(negedge clk);
        write_en = 1'b0;
        wdata = 16'h0000;
        addr = 19'h70;
        #1;
        chk("rst_bus_released", {16'h0, data}, 32'h0);
        chk("rst_mid_ready", {31'h0, ld_ready}, 32'h0);
        chk("rst_mid_words", {12'h0, ld_words}, 32'h0);
        chk("rst_mid_done", {31'h0, ld_done}, 32'h0);
        @(negedge clk);
        drv = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_after_done", {31'h0, ld_done}, 32'h0);
        chk("rst_after_ready", {31'h0, ld_ready}, 32'h0);
        mdl[idx(19'h70)] = 16'hAABB;
        bus_read(19'h70, "rst_kept_word");
        bus_read(19'h71, "rst_no_commit");
        bus_read(19'h72, "rst_write_ignored");

        // Pointer wrap at 19'h7FFFF and address aliasing
        start_load(19'h7FFFF);
        send_byte(8'hE1, 1'b0);
        send_byte(8'hE2, 1'b0);
        send_byte(8'hF1, 1'b0);
        send_byte(8'hF2, 1'b0);
        stop_pulse();
        wait_done("wrap");
        chk("wrap_words", {12'h0, ld_words}, 32'h2);
        mdl[idx(19'h7FFFF)] = 16'hE1E2;
        mdl[idx(19'h00000)] = 16'hF1F2;
        bus_read(19'h7FFFF, "wrap_first");
        bus_read(19'h00000, "wrap_second");
        bus_read(19'h10000, "alias_0x10000");

        // Randomized loads against random bus traffic
        for (int i = 0; i < 16; i++) bus_write(19'h0C000 + 19'(i), 16'($urandom));
        for (int r = 0; r < 4; r++) rand_round(r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
